enemy_move_scheduler: RTL and testbench

//  Sequences the enemy position FSM. Generates its step enable and random go bit,
//  and paces moves from the speed flag. It also drives the erase/redraw handshake to
//  the VGA drawer and schedules enemy punches (windup, then strike) from the attack flag.

---
 rtl/enemy_move_scheduler.sv | 171 +++++++++++++++++
 tb/tb_enemy_move_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_move_scheduler.sv
// enemy_move_scheduler
//   Paces and sequences one enemy: a free-running tick counter (period set by
//   speed) starts a move. Each move is a one-cycle step_en to the enemy FSM,
//   then an erase of the old slot and a redraw at the new slot through the VGA
//   drawer handshake. After every 2 moves (attack=1) or 4 moves (attack=0) it
//   telegraphs a punch (windup) and then strikes (punch). dead parks the block
//   until reset.
//
// Ports
//   clock      in   system clock
//   reset_n    in   synchronous active-low reset
//   speed      in   1 = halve the move period
//   attack     in   1 = strike every 2 moves, 0 = every 4
//   dead       in   enemy defeated, absorbing until reset
//   x_pos[1:0] in   current enemy slot (1 L, 2 M, 3 R)
//   draw_done  in   drawer finished the current request (1-cycle pulse)
//   step_en    out  one position update for the enemy FSM
//   go         out  pseudo-random direction bit for the enemy FSM
//   draw_req   out  drawer request, held until draw_done
//   erase      out  1 = paint background, 0 = paint sprite
//   draw_x     out  slot to paint
//   windup     out  punch telegraph
//   punch      out  1-cycle strike pulse
//   busy       out  not idle and not dead
module enemy_move_scheduler #(
  parameter int unsigned TICK_CALM  = 32,
  parameter int unsigned WINDUP_CYC = 8,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       speed,
  input  logic       attack,
  input  logic       dead,
  input  logic [1:0] x_pos,
  input  logic       draw_done,
  output logic       step_en,
  output logic       go,
  output logic       draw_req,
  output logic       erase,
  output logic [1:0] draw_x,
  output logic       windup,
  output logic       punch,
  output logic       busy
);

  localparam int unsigned TickW = (TICK_CALM > 2) ? $clog2(TICK_CALM) : 1;
  // One extra bit so the period itself (TICK_CALM) is representable.
  localparam int unsigned PW    = TickW + 1;
  localparam int unsigned WindW = (WINDUP_CYC > 1) ? $clog2(WINDUP_CYC) : 1;

  localparam logic [PW-1:0]    PeriodCalm = PW'(TICK_CALM);
  localparam logic [PW-1:0]    PeriodFast = PW'(TICK_CALM / 2);
  localparam logic [WindW-1:0] WindLast   = WindW'(WINDUP_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStep,
    StErase,
    StDraw,
    StWindup,
    StStrike,
    StDead
  } state_e;

  state_e           state_q, state_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]       move_cnt_q, move_cnt_d;
  logic [WindW-1:0] wind_cnt_q, wind_cnt_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [1:0]       prev_x_q, prev_x_d;

  logic [PW-1:0]    period;
  logic [PW-1:0]    tick_ext;
  logic             tick;
  logic [2:0]       move_new;
  logic [2:0]       move_limit;

  // Tick counter and LFSR run every cycle regardless of state.
  always_comb begin
    period     = speed ? PeriodFast : PeriodCalm;
    tick_ext   = {1'b0, tick_cnt_q};
    tick       = (tick_ext == period - PW'(1));
    // Also catches a count left above the fast period when speed rises.
    tick_cnt_d = (tick_ext + PW'(1) >= period) ? '0 : tick_cnt_q + TickW'(1);
    lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_comb begin
    state_d    = state_q;
    move_cnt_d = move_cnt_q;
    wind_cnt_d = wind_cnt_q;
    prev_x_d   = prev_x_q;
    move_new   = {1'b0, move_cnt_q} + 3'd1;
    move_limit = attack ? 3'd2 : 3'd4;

    if (dead) begin
      state_d = StDead;
    end else begin
      case (state_q)
        StIdle: begin
          if (tick) state_d = StStep;
        end
        StStep: begin
          // Enemy FSM updates x_pos on this edge; keep the old slot to erase.
          prev_x_d = x_pos;
          state_d  = StErase;
        end
        StErase: begin
          if (draw_done) state_d = StDraw;
        end
        StDraw: begin
          if (draw_done) begin
            if (move_new >= move_limit) begin
              move_cnt_d = 2'd0;
              wind_cnt_d = '0;
              state_d    = StWindup;
            end else begin
              move_cnt_d = move_new[1:0];
              state_d    = StIdle;
            end
          end
        end
        StWindup: begin
          if (wind_cnt_q == WindLast) begin
            state_d = StStrike;
          end else begin
            wind_cnt_d = wind_cnt_q + WindW'(1);
          end
        end
        StStrike: state_d = StIdle;
        StDead:   state_d = StDead;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      move_cnt_q <= 2'd0;
      wind_cnt_q <= '0;
      lfsr_q     <= LFSR_SEED;
      prev_x_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      move_cnt_q <= move_cnt_d;
      wind_cnt_q <= wind_cnt_d;
      lfsr_q     <= lfsr_d;
      prev_x_q   <= prev_x_d;
    end
  end

  // Outputs decode the state register only; draw_x in DRAW follows x_pos.
  always_comb begin
    step_en  = (state_q == StStep);
    // go is only consumed with step_en; gating keeps it 0 in reset and DEAD.
    go       = (state_q == StStep) & lfsr_q[0];
    draw_req = (state_q == StErase) || (state_q == StDraw);
    erase    = (state_q == StErase);
    windup   = (state_q == StWindup);
    punch    = (state_q == StStrike);
    busy     = (state_q != StIdle) && (state_q != StDead);
    draw_x   = 2'd0;
    if (state_q == StErase) draw_x = prev_x_q;
    if (state_q == StDraw)  draw_x = x_pos;
  end

endmodule

// File: tb/tb_enemy_move_scheduler.sv
module tb_enemy_move_scheduler;

  localparam int TC = 8;
  localparam int WC = 3;

  logic       clock;
  logic       reset_n;
  logic       speed;
  logic       attack;
  logic       dead;
  logic [1:0] x_pos;
  logic       draw_done;
  logic       step_en;
  logic       go;
  logic       draw_req;
  logic       erase;
  logic [1:0] draw_x;
  logic       windup;
  logic       punch;
  logic       busy;

  enemy_move_scheduler #(
    .TICK_CALM (TC),
    .WINDUP_CYC(WC),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .speed    (speed),
    .attack   (attack),
    .dead     (dead),
    .x_pos    (x_pos),
    .draw_done(draw_done),
    .step_en  (step_en),
    .go       (go),
    .draw_req (draw_req),
    .erase    (erase),
    .draw_x   (draw_x),
    .windup   (windup),
    .punch    (punch),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: move progress described as counts of outstanding work.
  bit         m_step;     // step pulse showing this cycle
  int         m_draws;    // drawer completions still owed for this move (2 erase, 1 draw)
  int         m_windup;   // windup cycles still to show
  bit         m_punch;
  bit         m_dead;
  int         m_moves;
  int         m_ticks;
  logic [7:0] m_lfsr;
  logic [1:0] m_prev_x;

  // Stimulus knobs, applied at the next negedge.
  logic       k_rst = 1'b0;
  logic       k_speed = 1'b0;
  logic       k_attack = 1'b0;
  logic       k_dead = 1'b0;
  logic [1:0] k_x = 2'd1;
  int         lat = 2;
  bit         stall = 0;
  bit         spurious = 0;
  bit         rand_lat = 0;
  int         d_cnt = 0;

  // Last observed DUT outputs.
  logic       o_step, o_req, o_erase, o_windup, o_punch, o_busy;
  logic [1:0] o_x;
  logic [8:0] o_vec;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_step = 0; m_draws = 0; m_windup = 0; m_punch = 0; m_dead = 0;
    m_moves = 0; m_ticks = 0; m_lfsr = 8'hA5; m_prev_x = 2'd0;
  endtask

  task automatic model_step(input logic rn, input logic sp, input logic at, input logic dd,
                            input logic [1:0] x, input logic done);
    int period;
    bit tk;
    if (!rn) begin
      model_reset();
      return;
    end
    m_lfsr  = lfsr_next(m_lfsr);
    period  = sp ? TC / 2 : TC;
    tk      = (m_ticks == period - 1);
    m_ticks = (m_ticks + 1 >= period) ? 0 : m_ticks + 1;
    if (dd || m_dead) begin
      m_dead = 1; m_step = 0; m_draws = 0; m_windup = 0; m_punch = 0;
    end else if (m_step) begin
      m_step = 0; m_prev_x = x; m_draws = 2;
    end else if (m_draws == 2) begin
      if (done) m_draws = 1;
    end else if (m_draws == 1) begin
      if (done) begin
        m_draws = 0;
        m_moves++;
        if (m_moves >= (at ? 2 : 4)) begin
          m_moves  = 0;
          m_windup = WC;
        end
      end
    end else if (m_windup > 0) begin
      m_windup--;
      if (m_windup == 0) m_punch = 1;
    end else if (m_punch) begin
      m_punch = 0;
    end else if (tk) begin
      m_step = 1;
    end
  endtask

  // One clock: compare outputs, then drive the next inputs and advance the model.
  task automatic cycle();
    logic [8:0] exp_vec;
    logic [1:0] exp_x;
    logic       done;
    bit         mbusy;
    @(negedge clock);
    exp_x   = (m_draws == 2) ? m_prev_x : ((m_draws == 1) ? x_pos : 2'd0);
    mbusy   = m_step || (m_draws > 0) || (m_windup > 0) || m_punch;
    exp_vec = {m_step, m_step & m_lfsr[0], m_draws > 0, m_draws == 2, exp_x,
               m_windup > 0, m_punch, mbusy};
    o_vec   = {step_en, go, draw_req, erase, draw_x, windup, punch, busy};
    o_step = step_en; o_req = draw_req; o_erase = erase; o_x = draw_x;
    o_windup = windup; o_punch = punch; o_busy = busy;
    check("outputs", {23'd0, o_vec}, {23'd0, exp_vec});

    done = 1'b0;
    if (m_draws > 0) begin
      d_cnt++;
      if (!stall && d_cnt >= lat) begin
        done  = 1'b1;
        d_cnt = 0;
        if (rand_lat) lat = $urandom_range(1, 4);
      end
    end else begin
      d_cnt = 0;
      done  = spurious && ($urandom_range(0, 7) == 0);
    end
    reset_n = k_rst; speed = k_speed; attack = k_attack; dead = k_dead;
    x_pos = k_x; draw_done = done;
    model_step(k_rst, k_speed, k_attack, k_dead, k_x, done);
  endtask

  task automatic do_reset(input int n);
    k_rst = 1'b0;
    repeat (n) cycle();
    k_rst = 1'b1;
  endtask

  task automatic run_to_punch(input int bound, output int steps, output int wu_at, output bit found);
    int wu;
    steps = 0; wu = 0; wu_at = 0; found = 0;
    for (int i = 0; i < bound && !found; i++) begin
      cycle();
      if (o_step) steps++;
      if (o_punch) begin
        found = 1;
        wu_at = wu;
      end
      wu = o_windup ? wu + 1 : 0;
    end
  endtask

  initial begin
    int first, steps, wu_at, cnt, reqs, orv;
    bit found;
    reset_n = 1'b0; speed = 1'b0; attack = 1'b0; dead = 1'b0;
    x_pos = 2'd1; draw_done = 1'b0;
    model_reset();

    // Reset release to first step, then erase/redraw of a 1->2 move.
    do_reset(3);
    cycle();
    check("reset_idle", {23'd0, o_vec}, 32'd0);
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (o_step) begin
        first = i;
        break;
      end
    end
    check("first_step_cycle", first, 8);
    k_x  = 2'd2;
    reqs = 0;
    cycle();
    check("erase_x_old", {o_req, o_erase, o_x}, {1'b1, 1'b1, 2'd1});
    reqs += o_req;
    cycle();
    reqs += o_req;
    cycle();
    check("draw_x_new", {o_req, o_erase, o_x}, {1'b1, 1'b0, 2'd2});
    reqs += o_req;
    cycle();
    reqs += o_req;
    cycle();
    check("req_run_len", reqs, 4);
    check("req_dropped", o_req, 1'b0);

    // attack=0: four moves then windup/strike; attack=1: every second move.
    run_to_punch(100, steps, wu_at, found);
    check("punch_found_calm", found, 1'b1);
    check("moves_per_punch_calm", steps + 1, 4);
    check("windup_len", wu_at, WC);
    cycle();
    check("punch_one_cycle", o_punch, 1'b0);
    k_attack = 1'b1;
    run_to_punch(100, steps, wu_at, found);
    check("moves_per_punch_attack", steps, 2);

    // Reset while winding up cancels the strike and the move count.
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle();
      if (o_windup) found = 1;
    end
    check("windup_seen", found, 1'b1);
    k_attack = 1'b0;
    k_rst    = 1'b0;
    cycle();
    k_rst = 1'b1;
    cycle();
    check("reset_kills_windup", {o_windup, o_punch, o_busy}, 3'b000);
    run_to_punch(120, steps, wu_at, found);
    check("moves_after_reset", steps, 4);

    // speed=1 with a one-cycle drawer, then a stalled drawer.
    do_reset(2);
    k_speed = 1'b1;
    lat = 1;
    cycle();
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (o_step) begin
        first = i;
        break;
      end
    end
    check("first_step_fast", first, 4);
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (o_step) begin
        first = i;
        break;
      end
    end
    check("step_spacing_fast", first, 4);
    stall = 1;
    cnt = 0; reqs = 0;
    repeat (20) begin
      cycle();
      cnt  += o_step;
      reqs += o_req;
    end
    check("stall_no_step", cnt, 0);
    check("stall_req_held", reqs, 20);
    stall = 0;
    lat   = 2;
    repeat (10) cycle();

    // dead during erase: everything drops and stays down until reset.
    k_speed = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (o_erase) found = 1;
    end
    check("erase_seen", found, 1'b1);
    k_dead = 1'b1;
    cycle();
    k_dead = 1'b0;
    cycle();
    check("dead_outputs", {23'd0, o_vec}, 32'd0);
    orv = 0;
    repeat (20) begin
      cycle();
      orv |= int'(o_vec);
    end
    check("dead_absorbing", orv, 0);
    do_reset(1);
    cycle();

    // Randomised traffic against the model.
    spurious = 1;
    rand_lat = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) k_speed = ~k_speed;
      if ($urandom_range(0, 19) == 0) k_attack = ~k_attack;
      if ($urandom_range(0, 3) == 0) k_x = 2'($urandom_range(1, 3));
      k_dead = ($urandom_range(0, 399) == 0);
      k_rst  = !(($urandom_range(0, 199) == 0) || (m_dead && $urandom_range(0, 9) == 0));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
